// File: rtl/hi_lo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states,
// iteration count and the operand magnitude helper.
package hi_lo_muldiv_pkg;

  typedef enum logic [2:0] {
    md_mult  = 3'd0,
    md_multu = 3'd1,
    md_div   = 3'd2,
    md_divu  = 3'd3,
    md_mthi  = 3'd4,
    md_mtlo  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    md_idle = 2'd0,
    md_calc = 2'd1,
    md_fix  = 2'd2
  } md_state_t;

  localparam int unsigned MD_ITERS = 32;
  localparam logic [4:0] MD_LAST = 5'(MD_ITERS - 1);

  // Absolute value for signed ops; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/hi_lo_muldiv_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module muldiv_div_step (
  input  logic [31:0] rem_in,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        q_bit
);

  logic [33:0] diff;

  // The partial remainder is always below the divisor, so the result fits in 32 bits.
  always_comb begin
    diff = {1'b0, rem_in, dividend_bit} - {2'b00, divisor};
    q_bit = ~diff[33];
    if (q_bit) begin
      rem_out = diff[31:0];
    end else begin
      rem_out = {rem_in[30:0], dividend_bit};
    end
  end

endmodule

// File: rtl/hi_lo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI and LO.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply path.
module hi_lo_muldiv
  import hi_lo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi_reg,
  output logic [31:0] lo_reg,
  output logic        busy,
  output logic        done
);

  md_state_t   state;
  logic [4:0]  count;
  logic        is_mul;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] dvd_raw;
  logic [31:0] opnd;
  // Multiply: {partial high, multiplier shifting out}. Divide: {remainder, quotient shifting in}.
  logic [63:0] acc;

  logic        signed_op;
  logic [32:0] mul_sum;
  logic [63:0] mul_res;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] step_rem;
  logic        step_q;

  muldiv_div_step u_div_step (
    .rem_in       (acc[63:32]),
    .dividend_bit (acc[31]),
    .divisor      (opnd),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // Shift-add step and the sign fix-ups applied on the FIX edge.
  always_comb begin
    signed_op = (op == md_mult) || (op == md_div);
    if (acc[0]) begin
      mul_sum = {1'b0, acc[63:32]} + {1'b0, opnd};
    end else begin
      mul_sum = {1'b0, acc[63:32]};
    end
    if (neg_res) begin
      mul_res = 64'd0 - acc;
      quo_fix = 32'd0 - acc[31:0];
    end else begin
      mul_res = acc;
      quo_fix = acc[31:0];
    end
    if (neg_rem) begin
      rem_fix = 32'd0 - acc[63:32];
    end else begin
      rem_fix = acc[63:32];
    end
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod;

  // Low 64 bits of the sign-extended product equal the signed product.
  always_comb begin
    if (op == md_mult) begin
      fast_prod = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    end else begin
      fast_prod = {32'd0, rs_data} * {32'd0, rt_data};
    end
  end
`endif

  // Control FSM with registered HI/LO, busy and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= md_idle;
      count    <= 5'd0;
      is_mul   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      dvd_raw  <= 32'd0;
      opnd     <= 32'd0;
      acc      <= 64'd0;
      hi_reg   <= 32'd0;
      lo_reg   <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        md_idle: begin
          done <= 1'b0;
          if (start) begin
            case (op)
              md_mthi: hi_reg <= rs_data;
              md_mtlo: lo_reg <= rs_data;
`ifdef MULDIV_FAST_MULT_EN
              md_mult, md_multu: begin
                is_mul  <= 1'b1;
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
                acc     <= fast_prod;
                busy    <= 1'b1;
                state   <= md_fix;
              end
`else
              md_mult, md_multu: begin
                is_mul  <= 1'b1;
                neg_res <= signed_op & (rs_data[31] ^ rt_data[31]);
                neg_rem <= 1'b0;
                opnd    <= md_mag(rs_data, signed_op);
                acc     <= {32'd0, md_mag(rt_data, signed_op)};
                count   <= MD_LAST;
                busy    <= 1'b1;
                state   <= md_calc;
              end
`endif
              md_div, md_divu: begin
                is_mul   <= 1'b0;
                neg_res  <= signed_op & (rs_data[31] ^ rt_data[31]);
                neg_rem  <= signed_op & rs_data[31];
                div_zero <= (rt_data == 32'd0);
                dvd_raw  <= rs_data;
                opnd     <= md_mag(rt_data, signed_op);
                acc      <= {32'd0, md_mag(rs_data, signed_op)};
                count    <= MD_LAST;
                busy     <= 1'b1;
                state    <= md_calc;
              end
              default: begin
                state <= md_idle;
              end
            endcase
          end
        end
        md_calc: begin
          if (is_mul) begin
            acc <= {mul_sum, acc[31:1]};
          end else begin
            acc <= {step_rem, acc[30:0], step_q};
          end
          if (count == 5'd0) begin
            state <= md_fix;
          end else begin
            count <= count - 5'd1;
          end
        end
        md_fix: begin
          if (is_mul) begin
            hi_reg <= mul_res[63:32];
            lo_reg <= mul_res[31:0];
          end else if (div_zero) begin
            hi_reg <= dvd_raw;
            lo_reg <= 32'hFFFF_FFFF;
          end else begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= md_idle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= md_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Randomized self-checking bench for hi_lo_muldiv against an arithmetic model of HI/LO.
module tb_hi_lo_muldiv;
  import hi_lo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  hi_lo_muldiv dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_reg(hi_reg), .lo_reg(lo_reg), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics straight from the instruction definitions.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      md_mult: begin
        sp = longint'(sa) * longint'(sb);
        m_hi = sp[63:32];
        m_lo = sp[31:0];
      end
      md_multu: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      md_div: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else begin
          m_lo = sa / sb; m_hi = sa % sb;
        end
      end
      md_divu: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      md_mthi: m_hi = a;
      md_mtlo: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_latency(input logic [2:0] o);
`ifdef MULDIV_FAST_MULT_EN
    if (o == md_mult || o == md_multu) return 1;
`endif
    return 33;
  endfunction

  // Issue one op; inj > 0 holds an MTHI 0x12345678 request at that cycle of the op.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [31:0] old_hi, old_lo;
    int cycles;
    old_hi = m_hi;
    old_lo = m_lo;
    model_apply(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == md_mthi || o == md_mtlo) begin
      check_val("mt_hi", hi_reg, m_hi);
      check_val("mt_lo", lo_reg, m_lo);
      check_val("mt_busy", busy, 1'b0);
      check_val("mt_done", done, 1'b0);
      return;
    end
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      check_val("busy_during", busy, 1'b1);
      check_val("hold", {hi_reg, lo_reg}, {old_hi, old_lo});
      if (inj > 0 && cycles == inj) begin
        start = 1'b1; op = md_mthi; rs_data = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check_val("latency", 64'(cycles), 64'(exp_latency(o)));
    check_val("res_hi", hi_reg, m_hi);
    check_val("res_lo", lo_reg, m_lo);
    check_val("busy_after", busy, 1'b0);
    @(posedge clk); #1;
    check_val("done_pulse", done, 1'b0);
    check_val("stable_hi", hi_reg, m_hi);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen_done;
    logic [2:0] rop;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hi", hi_reg, 32'd0);
    check_val("rst_lo", lo_reg, 32'd0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run_op(md_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(md_mult, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(md_div, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(md_divu, 32'd100, 32'd0, 0);
    run_op(md_div, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(md_div, 32'hFFFF_FFF0, 32'd0, 0);
    run_op(md_divu, 32'hDEAD_BEEF, 32'd1234, 5);
    check_val("no_mthi", hi_reg == 32'h1234_5678, 1'b0);
    run_op(md_multu, 32'h0001_0000, 32'h0001_0000, 0);
    run_op(md_divu, 32'd9, 32'd4, 0);

    // Abort an iterative op with reset part way through.
    @(negedge clk);
`ifdef MULDIV_FAST_MULT_EN
    start = 1'b1; op = md_divu;
`else
    start = 1'b1; op = md_mult;
`endif
    rs_data = 32'd123; rt_data = 32'd456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_val("abort_hi", hi_reg, 32'd0);
    check_val("abort_lo", lo_reg, 32'd0);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_done", done, 1'b0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done = seen_done | done;
    end
    check_val("abort_no_done", seen_done, 1'b0);
    run_op(md_mtlo, 32'hA5A5_A5A5, 32'd0, 0);
    check_val("mtlo_hi_kept", hi_reg, 32'd0);
    run_op(md_mthi, 32'h0BAD_F00D, 32'd0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 5));
      run_op(rop, pick(), pick(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
